// File: rtl/keyboard_emulator.sv
// keyboard_emulator: PS/2 device-side keystroke transmitter.
// Each accepted request is sent as make code, hold, F0, gap, code. The module drives
// both PS/2 lines and aborts and resends the current frame when the host inhibits the clock.
// Optional build macro KEY_E0_PREFIX_EN: left/right send E0-prefixed extended sequences.
module keyboard_emulator #(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned BYTE_GAP    = 25000,
    parameter int unsigned HOLD_CYCLES = 50000,
    parameter int unsigned INHIBIT_MIN = 5000
) (
    input  logic clock,
    input  logic resetn,
    input  logic go,
    input  logic left,
    input  logic right,
    input  logic ps2_clk_i,
    output logic ps2_clk_o,
    output logic ps2_dat_o,
    output logic busy,
    output logic done
);

    localparam int unsigned GapMaxA = (BYTE_GAP > HOLD_CYCLES) ? BYTE_GAP : HOLD_CYCLES;
    localparam int unsigned GapMax  = (GapMaxA > INHIBIT_MIN) ? GapMaxA : INHIBIT_MIN;
    localparam int unsigned HalfW   = $clog2(HALF_PERIOD);
    localparam int unsigned GapW    = $clog2(GapMax + 1);

    localparam logic [HalfW-1:0] HalfLast    = HalfW'(HALF_PERIOD - 1);
    localparam logic [GapW-1:0]  ByteGapLast = GapW'(BYTE_GAP - 1);
    localparam logic [GapW-1:0]  HoldLast    = GapW'(HOLD_CYCLES - 1);
    localparam logic [GapW-1:0]  InhibitLast = GapW'(INHIBIT_MIN - 1);

    localparam logic [7:0] CodeSpace = 8'h29;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;
    localparam logic [7:0] CodeBreak = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StBitHi,
        StBitLo,
        StGap,
        StInhibit,
        StFinish
    } state_e;

    state_e           r_state, w_state;
    logic [7:0]       r_code, w_code;
    logic [2:0]       r_byte_idx, w_byte_idx;
    logic [10:0]      r_frame, w_frame;
    logic [3:0]       r_bit_idx, w_bit_idx;
    logic [HalfW-1:0] r_half_cnt, w_half_cnt;
    logic [GapW-1:0]  r_gap_cnt, w_gap_cnt;
    logic             r_clk_s1, r_clk_s2;

    logic [7:0]       w_byte;
    logic [2:0]       w_last_idx;
    logic [2:0]       w_hold_idx;

`ifdef KEY_E0_PREFIX_EN
    logic             r_ext, w_ext;
`endif

    // Two-flop synchroniser for the host-driven clock line.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
        end
    end

    // Select the byte for the current sequence position and where the hold interval falls.
    always_comb begin
        w_byte     = r_code;
        w_last_idx = 3'd2;
        w_hold_idx = 3'd0;
`ifdef KEY_E0_PREFIX_EN
        if (r_ext) begin
            w_last_idx = 3'd4;
            w_hold_idx = 3'd1;
            case (r_byte_idx)
                3'd0:    w_byte = 8'hE0;
                3'd2:    w_byte = 8'hE0;
                3'd3:    w_byte = CodeBreak;
                default: w_byte = r_code;
            endcase
        end else if (r_byte_idx == 3'd1) begin
            w_byte = CodeBreak;
        end
`else
        if (r_byte_idx == 3'd1) begin
            w_byte = CodeBreak;
        end
`endif
    end

    // Next-state and datapath updates for the transmit sequencer.
    always_comb begin
        w_state    = r_state;
        w_code     = r_code;
        w_byte_idx = r_byte_idx;
        w_frame    = r_frame;
        w_bit_idx  = r_bit_idx;
        w_half_cnt = r_half_cnt;
        w_gap_cnt  = r_gap_cnt;
`ifdef KEY_E0_PREFIX_EN
        w_ext      = r_ext;
`endif
        case (r_state)
            StIdle: begin
                if (go || left || right) begin
                    w_state    = StLoad;
                    w_byte_idx = 3'd0;
                    if (go) begin
                        w_code = CodeSpace;
                    end else if (left) begin
                        w_code = CodeLeft;
                    end else begin
                        w_code = CodeRight;
                    end
`ifdef KEY_E0_PREFIX_EN
                    w_ext = !go;
`endif
                end
            end
            StLoad: begin
                // Frame bit 0 is the start bit; bit 9 is odd parity, bit 10 the stop bit.
                w_frame   = {1'b1, ~^w_byte, w_byte, 1'b0};
                w_bit_idx = 4'd0;
                w_state   = StCheck;
            end
            StCheck: begin
                if (r_clk_s2) begin
                    w_state    = StBitHi;
                    w_bit_idx  = 4'd0;
                    w_half_cnt = '0;
                end
            end
            StBitHi: begin
                // Once the stop bit is on the line the byte counts as sent.
                if (!r_clk_s2 && (r_bit_idx <= 4'd9)) begin
                    w_state   = StInhibit;
                    w_gap_cnt = '0;
                end else if (r_half_cnt == HalfLast) begin
                    w_half_cnt = '0;
                    w_state    = StBitLo;
                end else begin
                    w_half_cnt = r_half_cnt + 1'b1;
                end
            end
            StBitLo: begin
                if (r_half_cnt == HalfLast) begin
                    w_half_cnt = '0;
                    if (r_bit_idx == 4'd10) begin
                        w_gap_cnt = '0;
                        w_state   = (r_byte_idx == w_last_idx) ? StFinish : StGap;
                    end else begin
                        w_bit_idx = r_bit_idx + 1'b1;
                        w_state   = StBitHi;
                    end
                end else begin
                    w_half_cnt = r_half_cnt + 1'b1;
                end
            end
            StGap: begin
                if (r_gap_cnt == ((r_byte_idx == w_hold_idx) ? HoldLast : ByteGapLast)) begin
                    w_byte_idx = r_byte_idx + 1'b1;
                    w_state    = StLoad;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            StInhibit: begin
                // Needs an unbroken run of high samples before retrying the same frame.
                if (!r_clk_s2) begin
                    w_gap_cnt = '0;
                end else if (r_gap_cnt == InhibitLast) begin
                    w_state = StCheck;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            StFinish: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_code     <= '0;
            r_byte_idx <= '0;
            r_frame    <= '0;
            r_bit_idx  <= '0;
            r_half_cnt <= '0;
            r_gap_cnt  <= '0;
`ifdef KEY_E0_PREFIX_EN
            r_ext      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_code     <= w_code;
            r_byte_idx <= w_byte_idx;
            r_frame    <= w_frame;
            r_bit_idx  <= w_bit_idx;
            r_half_cnt <= w_half_cnt;
            r_gap_cnt  <= w_gap_cnt;
`ifdef KEY_E0_PREFIX_EN
            r_ext      <= w_ext;
`endif
        end
    end

    // Line drives decode straight from state so reset releases them without waiting a clock.
    always_comb begin
        ps2_clk_o = (r_state != StBitLo);
        ps2_dat_o = 1'b1;
        if ((r_state == StBitHi) || (r_state == StBitLo)) begin
            ps2_dat_o = r_frame[r_bit_idx];
        end
        busy = (r_state != StIdle) && (r_state != StFinish);
        done = (r_state == StFinish);
    end

endmodule

// File: tb/tb_keyboard_emulator.sv
// tb_keyboard_emulator: directed bench for keyboard_emulator with a PS/2 line decoder.
// Build with KEY_E0_PREFIX_EN defined to check the extended-arrow sequences instead.
module tb_keyboard_emulator;

    localparam int unsigned HP   = 4;
    localparam int unsigned GAP  = 20;
    localparam int unsigned HOLD = 20;
    localparam int unsigned IMIN = 10;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic go = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic ps2_clk_i = 1'b1;
    logic ps2_clk_o, ps2_dat_o, busy, done;

    int total = 0;
    int bad = 0;

    keyboard_emulator #(
        .HALF_PERIOD(HP),
        .BYTE_GAP   (GAP),
        .HOLD_CYCLES(HOLD),
        .INHIBIT_MIN(IMIN)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .go       (go),
        .left     (left),
        .right    (right),
        .ps2_clk_i(ps2_clk_i),
        .ps2_clk_o(ps2_clk_o),
        .ps2_dat_o(ps2_dat_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Line decoder: host-style sampling on falling edges of the device clock.
    int          cyc = 0;
    int          nbits = 0;
    int          t_start = 0;
    int          last_fall = 0;
    int          done_cnt = 0;
    int          done_busy_err = 0;
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    logic [10:0] cur = '0;
    logic [10:0] fr_q[$];
    int          len_q[$];
    int          start_q[$];

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (!resetn) begin
            nbits = 0;
        end else begin
            if (done) begin
                done_cnt = done_cnt + 1;
                if (busy) done_busy_err = done_busy_err + 1;
            end
            if (nbits == 0 && prev_dat && !ps2_dat_o) t_start = cyc;
            if (prev_clk && !ps2_clk_o && nbits < 11) begin
                cur[nbits] = ps2_dat_o;
                nbits = nbits + 1;
                last_fall = cyc;
            end
            if (!prev_clk && ps2_clk_o && nbits == 11) begin
                fr_q.push_back(cur);
                len_q.push_back(cyc - t_start);
                start_q.push_back(t_start);
                nbits = 0;
            end
            // A partial frame that stalls is an aborted one; drop it.
            if (nbits > 0 && nbits < 11 && (cyc - last_fall) > 20) nbits = 0;
        end
        prev_clk = ps2_clk_o;
        prev_dat = ps2_dat_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input int i, input logic [7:0] b, input logic p);
        logic [10:0] fr;
        int          len;
        fr  = 'x;
        len = -1;
        if (i < fr_q.size()) begin
            fr  = fr_q[i];
            len = len_q[i];
        end
        chk($sformatf("frame%0d data", i), {24'd0, fr[8:1]}, {24'd0, b});
        chk($sformatf("frame%0d parity", i), {31'd0, fr[9]}, {31'd0, p});
        chk($sformatf("frame%0d start/stop", i), {30'd0, fr[10], fr[0]}, 32'd2);
        chk($sformatf("frame%0d length", i), len, 88);
    endtask

    task automatic flush();
        fr_q.delete();
        len_q.delete();
        start_q.delete();
    endtask

    task automatic pulse(input logic g, input logic l, input logic r);
        @(negedge clock); #2;
        go = g; left = l; right = r;
        @(negedge clock); #2;
        go = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clock); #2;
            n++;
        end
        chk(tag, done_cnt - base, 1);
        repeat (3) @(negedge clock);
        #2;
    endtask

    task automatic wait_bits(input int want, input string tag);
        int n;
        n = 0;
        while (nbits != want && n < 1000) begin
            @(negedge clock); #2;
            n++;
        end
        chk(tag, nbits, want);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    initial begin
        int base_done;
        int t_rel;

        // Reset and quiet idle.
        repeat (3) @(negedge clock);
        #2;
        chk("reset lines", {28'd0, ps2_clk_o, ps2_dat_o, busy, done}, 32'hC);
        resetn = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock); #2;
            chk("idle lines", {28'd0, ps2_clk_o, ps2_dat_o, busy, done}, 32'hC);
        end

        // Space keystroke.
        flush();
        base_done = done_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        chk("busy after go", {31'd0, busy}, 32'd1);
        wait_done("space done");
        chk("space frames", fr_q.size(), 3);
        chk_frame(0, 8'h29, 1'b0);
        chk_frame(1, 8'hF0, 1'b1);
        chk_frame(2, 8'h29, 1'b0);
        chk("space done count", done_cnt - base_done, 1);
        chk("done with busy", done_busy_err, 0);
        chk("idle after space", {28'd0, ps2_clk_o, ps2_dat_o, busy, done}, 32'hC);

        // Left and right together; a later right is dropped.
        flush();
        base_done = done_cnt;
        pulse(1'b0, 1'b1, 1'b1);
        idle_cycles(150);
        chk("busy mid keystroke", {31'd0, busy}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        wait_done("left done");
        idle_cycles(300);
`ifdef KEY_E0_PREFIX_EN
        chk("left frames", fr_q.size(), 5);
        chk_frame(0, 8'hE0, 1'b0);
        chk_frame(1, 8'h6B, 1'b0);
        chk_frame(2, 8'hE0, 1'b0);
        chk_frame(3, 8'hF0, 1'b1);
        chk_frame(4, 8'h6B, 1'b0);
`else
        chk("left frames", fr_q.size(), 3);
        chk_frame(0, 8'h6B, 1'b0);
        chk_frame(1, 8'hF0, 1'b1);
        chk_frame(2, 8'h6B, 1'b0);
`endif
        chk("left done count", done_cnt - base_done, 1);
        chk("idle after left", {31'd0, busy}, 32'd0);

        // Right with host inhibit during data bit 3 of the first byte.
        flush();
        pulse(1'b0, 1'b0, 1'b1);
        wait_bits(4, "reach bit3");
        begin
            int n;
            n = 0;
            while (!ps2_clk_o && n < 100) begin
                @(negedge clock); #2;
                n++;
            end
            chk("bit3 high phase", {31'd0, ps2_clk_o}, 32'd1);
        end
        ps2_clk_i = 1'b0;
        idle_cycles(10);
        chk("inhibit released", {29'd0, ps2_clk_o, ps2_dat_o, busy}, 32'h7);
        idle_cycles(90);
        chk("no frame in inhibit", fr_q.size(), 0);
        ps2_clk_i = 1'b1;
        t_rel = cyc;
        wait_done("right done");
        chk("restart delay", (start_q.size() > 0) ? start_q[0] - t_rel : -1, IMIN + 3);
`ifdef KEY_E0_PREFIX_EN
        chk("right frames", fr_q.size(), 5);
        chk_frame(0, 8'hE0, 1'b0);
        chk_frame(1, 8'h74, 1'b1);
        chk_frame(2, 8'hE0, 1'b0);
        chk_frame(3, 8'hF0, 1'b1);
        chk_frame(4, 8'h74, 1'b1);
`else
        chk("right frames", fr_q.size(), 3);
        chk_frame(0, 8'h74, 1'b1);
        chk_frame(1, 8'hF0, 1'b1);
        chk_frame(2, 8'h74, 1'b1);
`endif

        // Reset in the middle of a start bit.
        flush();
        pulse(1'b1, 1'b0, 1'b0);
        wait_bits(1, "reach start low");
        chk("pre-reset lines", {30'd0, ps2_clk_o, ps2_dat_o}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("async reset lines", {28'd0, ps2_clk_o, ps2_dat_o, busy, done}, 32'hC);
        idle_cycles(3);
        resetn = 1'b1;
        idle_cycles(2);
        flush();
        base_done = done_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        wait_done("post-reset done");
        chk("post-reset frames", fr_q.size(), 3);
        chk_frame(0, 8'h29, 1'b0);
        chk_frame(1, 8'hF0, 1'b1);
        chk_frame(2, 8'h29, 1'b0);
        chk("post-reset done count", done_cnt - base_done, 1);
        chk("done with busy final", done_busy_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keyboard_emulator.md
Name: keyboard_emulator

Overview:
- PS/2 device-side transmitter: turns single-cycle key requests (space, left, right) into complete keystrokes on the PS/2 clock/data lines. Each keystroke is a make code, a hold interval, then break code F0 followed by the key code.
- Drives both PS/2 lines as the device does, clock included. Used as a board-level keyboard stand-in and as the stimulus source for the keyboard FSM bench.
- Host clock inhibit is honoured by aborting the current frame and retransmitting it.

Parameters:
- HALF_PERIOD, 2000, system clocks per PS/2 clock half-phase (12.5 kHz at 50 MHz); minimum 2.
- BYTE_GAP, 25000, idle cycles (both lines high) between consecutive bytes of one keystroke.
- HOLD_CYCLES, 50000, idle cycles between the last make byte and the F0 byte.
- INHIBIT_MIN, 5000, cycles host clock must be seen high again before retransmit after an inhibit.

Ports:
- clock  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- go  in  1  request space keystroke (code 29), one-cycle pulse
- left  in  1  request left keystroke (code 6B)
- right  in  1  request right keystroke (code 74)
- ps2_clk_i  in  1  sampled PS/2 clock line (host may hold it low)
- ps2_clk_o  out  1  device clock drive; 0 = pull low, 1 = release
- ps2_dat_o  out  1  device data drive; 0 = pull low, 1 = release
- busy  out  1  keystroke in progress; requests ignored while high
- done  out  1  one-cycle pulse after final stop bit of the break byte

Behaviour:
- Reset (async, resetn=0): ps2_clk_o=1, ps2_dat_o=1, busy=0, done=0, state IDLE, all counters 0. Asserting reset mid-frame releases both lines immediately; no partial frame is resumed.
- Request accept: in IDLE only. Priority go > left > right when several are high in the same cycle. Key code is latched and busy=1 from the next cycle. Requests while busy=1 are dropped.
- Byte sequence per keystroke: [code], hold, F0, gap, [code]. The Optional Feature inserts an E0 prefix.
- Frame format: 11 bits — start 0, data[0..7] LSB first, odd parity, stop 1.
- Bit timing:
  - ps2_dat_o changes only at the start of a clock-high phase.
  - Each bit is HALF_PERIOD cycles with clk high, then HALF_PERIOD cycles with clk low. The host samples on the falling edge.
  - Frame length: 22*HALF_PERIOD cycles. Clock ends high; data is released after the stop bit.
- States:
  - IDLE: accept a request.
  - LOAD: select next byte, compute parity, bit index=0.
  - CHECK: start the frame only if ps2_clk_i=1; otherwise wait.
  - BIT_HI, then BIT_LO: 11 iterations.
  - GAP: wait BYTE_GAP, or HOLD_CYCLES after the last make byte.
  - INHIBIT: abort handling.
  - FINISH: done=1 for one cycle, busy=0, back to IDLE.
- Inhibit: ps2_clk_i=0 sampled during a BIT_HI phase, with bit index ≤ 9 (before parity completes), aborts the frame.
  - Release both lines and enter INHIBIT.
  - Return to CHECK once ps2_clk_i has been high for INHIBIT_MIN consecutive cycles, then resend the same byte from the start bit.
  - Inhibit seen during the stop bit is ignored; the byte counts as sent.
- ps2_clk_i is double-flop synchronised internally. The two cycles of latency are included in all inhibit timing.
- Counters: half-phase counter ceil(log2(HALF_PERIOD)) bits. Gap counter sized for max(BYTE_GAP, HOLD_CYCLES, INHIBIT_MIN).

Optional Feature:
- Macro KEY_E0_PREFIX_EN.
- Defined: left/right send the real extended-arrow sequence: E0 6B, hold, E0 F0 6B (likewise 74). Space is unchanged (29, F0, 29).
- Undefined: no E0 bytes for any key (6B, F0, 6B) — the sequence the existing keyboard FSM decodes.

Test Plan:
- Reset, then hold resetn=1 with no requests for 10000 cycles -> ps2_clk_o=1, ps2_dat_o=1, busy=0, done=0 throughout.
- go pulse, HALF_PERIOD=4, BYTE_GAP=HOLD_CYCLES=20 -> falling-edge samples decode, in order:
  - 0x29 with parity 0
  - 0xF0 with parity 1
  - 0x29 with parity 0
  - each frame 11 falling edges and 88 cycles long
  - done pulses once; busy drops the same cycle.
- left and right pulsed in the same cycle -> only 6B / F0 / 6B (parity 0, 1, 0) sent. A right pulse mid-keystroke is dropped.
- right pulse; bench drives ps2_clk_i=0 for 100 cycles during data bit 3 of the first byte -> frame aborted, lines released. After INHIBIT_MIN cycles high, 0x74 (parity 1) is resent in full; total output is 74, F0, 74.
- resetn pulsed low mid-frame -> both outputs 1 within the same cycle, busy=0. A subsequent go produces a clean 29/F0/29.
- With KEY_E0_PREFIX_EN, left pulse -> E0, 6B, E0, F0, 6B, each frame with correct odd parity (E0 parity 0).
